// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: core-wide defaults,
// well-known register numbers and the clear/run state type.
package regfile_mp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bus of the register file: two write ports, packed
// read ports with busy flags, the issue strobe and the ready indication.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic                     ready;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, issue_en, issue_addr,
        input  ready, rdata, rbusy
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, issue_en, issue_addr,
        output ready, rdata, rbusy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set on issue, cleared on writeback, looked up
// per read port with same-cycle writes masking the busy indication.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_run,
    input  logic                     i_set,
    input  logic [ADDR_W-1:0]        i_set_addr,
    input  logic                     i_clr0,
    input  logic [ADDR_W-1:0]        i_clr0_addr,
    input  logic                     i_clr1,
    input  logic [ADDR_W-1:0]        i_clr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD-1:0]        o_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_busy;

    // A new issue outranks a retiring write to the same register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (i_set && (i_set_addr == ADDR_W'(a)) && !((ZERO_REG != 0) && (a == 0))) begin
                    r_busy[a] <= 1'b1;
                end else if ((i_clr0 && (i_clr0_addr == ADDR_W'(a))) ||
                             (i_clr1 && (i_clr1_addr == ADDR_W'(a)))) begin
                    r_busy[a] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        logic [ADDR_W-1:0] w_ra;
        logic              w_wr_hit;
        assign w_ra     = i_raddr[k*ADDR_W +: ADDR_W];
        assign w_wr_hit = (i_clr0 && (i_clr0_addr == w_ra)) || (i_clr1 && (i_clr1_addr == w_ra));
        assign o_busy[k] = i_run && r_busy[w_ra] && !w_wr_hit;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and a
// post-reset clear sequencer so the storage array needs no reset.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_INIT | zeroing entry r_clr_cnt each cycle; traffic ignored, ready=0
//  ST_RUN  | normal reads, writes and issues; ready=1
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    regfile_mp_if.slave  s_bus
);
    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    rf_state_e         r_state;
    logic              r_ready;
    logic [ADDR_W:0]   r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_run;
    logic w_wv0;
    logic w_wv1;
    logic w_issue;

    assign w_run   = (r_state == ST_RUN);
    assign w_wv0   = s_bus.we0 && w_run && !((ZERO_REG != 0) && (s_bus.waddr0 == '0));
    assign w_wv1   = s_bus.we1 && w_run && !((ZERO_REG != 0) && (s_bus.waddr1 == '0));
    assign w_issue = s_bus.issue_en && w_run;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_INIT;
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
        end else begin
            if (w_wv0) r_mem[s_bus.waddr0] <= s_bus.wdata0;
            if (w_wv1) r_mem[s_bus.waddr1] <= s_bus.wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = s_bus.raddr[k*ADDR_W +: ADDR_W];
        assign s_bus.rdata[k*DATA_W +: DATA_W] =
            (!w_run || ((ZERO_REG != 0) && (w_ra == '0))) ? '0 :
            (w_wv1 && (s_bus.waddr1 == w_ra))             ? s_bus.wdata1 :
            (w_wv0 && (s_bus.waddr0 == w_ra))             ? s_bus.wdata0 :
                                                             r_mem[w_ra];
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_run       (w_run),
        .i_set       (w_issue),
        .i_set_addr  (s_bus.issue_addr),
        .i_clr0      (w_wv0),
        .i_clr0_addr (s_bus.waddr0),
        .i_clr1      (w_wv1),
        .i_clr1_addr (s_bus.waddr1),
        .i_raddr     (s_bus.raddr),
        .o_busy      (s_bus.rbusy)
    );

    assign s_bus.ready = r_ready;

endmodule
